// File: rtl/ex_forward_ctrl.sv
// EX-stage operand forwarding control: tracks in-flight destination tags, produces registered
// rs1/rs2 forwarding selects, load-use stall and redirect flush. Optional counters: HAZARD_PERF_EN.
module ex_forward_ctrl #(
  parameter int REG_AW = 5,
  parameter int FWD_W  = 2,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              ex_redirect,
  output logic [FWD_W-1:0]  fwd_rs1_sel,
  output logic [FWD_W-1:0]  fwd_rs2_sel,
  output logic              stall,
  output logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [FWD_W-1:0]  SEL_RF  = FWD_W'(2'b00);
  localparam logic [FWD_W-1:0]  SEL_MEM = FWD_W'(2'b01);
  localparam logic [FWD_W-1:0]  SEL_WB  = FWD_W'(2'b10);
  localparam logic [REG_AW-1:0] REG_X0  = {REG_AW{1'b0}};

  // A source matches a producer only when it is really read and really written (x0 never).
  function automatic logic src_match(input logic              use_bit,
                                     input logic [REG_AW-1:0] src,
                                     input logic [REG_AW-1:0] dst,
                                     input logic              wr);
    return use_bit & wr & (dst != REG_X0) & (src == dst);
  endfunction

  // The WB-stage tag is never consulted: a select is chosen when the consumer enters EX,
  // looking back only at EX and MEM, so the tag leaving MEM needs no storage here.
  logic [REG_AW-1:0] ex_rd_r, mem_rd_r;
  logic              ex_rw_r, mem_rw_r;
  logic              ex_mr_r;
  logic [FWD_W-1:0]  sel1_r, sel2_r;

  logic              load_hit_s;
  logic              stall_s;
  logic              flush_s;
  logic              bubble_s;
  logic [FWD_W-1:0]  sel1_nxt_s, sel2_nxt_s;

  // Hazard detection and next-select selection for the instruction now in ID.
  always_comb begin
    flush_s    = ex_redirect;
    load_hit_s = src_match(id_use_rs1, id_rs1_addr, ex_rd_r, ex_rw_r) |
                 src_match(id_use_rs2, id_rs2_addr, ex_rd_r, ex_rw_r);
    stall_s    = ~flush_s & ex_mr_r & load_hit_s;
    bubble_s   = stall_s | flush_s;
    sel1_nxt_s = SEL_RF;
    sel2_nxt_s = SEL_RF;
    if (bubble_s) begin
      sel1_nxt_s = SEL_RF;
      sel2_nxt_s = SEL_RF;
    end else begin
      if (src_match(id_use_rs1, id_rs1_addr, ex_rd_r, ex_rw_r)) begin
        sel1_nxt_s = SEL_MEM;
      end else if (src_match(id_use_rs1, id_rs1_addr, mem_rd_r, mem_rw_r)) begin
        sel1_nxt_s = SEL_WB;
      end else begin
        sel1_nxt_s = SEL_RF;
      end
      if (src_match(id_use_rs2, id_rs2_addr, ex_rd_r, ex_rw_r)) begin
        sel2_nxt_s = SEL_MEM;
      end else if (src_match(id_use_rs2, id_rs2_addr, mem_rd_r, mem_rw_r)) begin
        sel2_nxt_s = SEL_WB;
      end else begin
        sel2_nxt_s = SEL_RF;
      end
    end
  end

  // Shadow tag pipeline and select registers; hold freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd_r  <= REG_X0;
      ex_rw_r  <= 1'b0;
      ex_mr_r  <= 1'b0;
      mem_rd_r <= REG_X0;
      mem_rw_r <= 1'b0;
      sel1_r   <= SEL_RF;
      sel2_r   <= SEL_RF;
    end else if (!hold) begin
      mem_rd_r <= ex_rd_r;
      mem_rw_r <= ex_rw_r;
      if (bubble_s) begin
        ex_rd_r <= REG_X0;
        ex_rw_r <= 1'b0;
        ex_mr_r <= 1'b0;
      end else begin
        ex_rd_r <= id_rd_addr;
        ex_rw_r <= id_reg_write;
        ex_mr_r <= id_mem_read;
      end
      sel1_r <= sel1_nxt_s;
      sel2_r <= sel2_nxt_s;
    end
  end

`ifdef HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

  // Saturating hazard counters, frozen while hold is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else if (!hold) begin
      if (stall_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (flush_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`else
  assign stall_cnt = {CNT_W{1'b0}};
  assign flush_cnt = {CNT_W{1'b0}};
`endif

  assign fwd_rs1_sel = sel1_r;
  assign fwd_rs2_sel = sel2_r;
  assign stall       = stall_s;
  assign flush       = flush_s;

endmodule

// File: tb/tb_ex_forward_ctrl.sv
// Self-checking bench for ex_forward_ctrl: directed pipeline scenarios plus random traffic,
// compared against a history-queue reference model.
module tb_ex_forward_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
  logic        ex_redirect;
  logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
  logic        stall, flush;
  logic [31:0] stall_cnt, flush_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ex_forward_ctrl dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_redirect(ex_redirect),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
    .stall(stall), .flush(flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Reference model: hist[0] is the instruction in EX, hist[1] the one in MEM, hist[2] in WB.
  typedef struct packed {
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } tag_t;

  tag_t        hist[$];
  logic [1:0]  m_sel1, m_sel2;
  int unsigned m_scnt, m_fcnt;

  task automatic model_reset();
    hist.delete();
    repeat (3) hist.push_back('0);
    m_sel1 = 2'd0;
    m_sel2 = 2'd0;
    m_scnt = 0;
    m_fcnt = 0;
  endtask

  // Nearest older writer of addr: one instruction ahead -> 01, two ahead -> 10.
  function automatic logic [1:0] m_fwd(input logic use_bit, input logic [4:0] addr);
    for (int d = 0; d < 2; d++) begin
      if (use_bit && hist[d].rw && hist[d].rd != 5'd0 && hist[d].rd == addr)
        return (d == 0) ? 2'b01 : 2'b10;
    end
    return 2'b00;
  endfunction

  function automatic logic m_stall();
    tag_t p;
    p = hist[0];
    if (ex_redirect || !p.mr || !p.rw || p.rd == 5'd0) return 1'b0;
    return (id_use_rs1 && id_rs1_addr == p.rd) || (id_use_rs2 && id_rs2_addr == p.rd);
  endfunction

  task automatic model_edge();
    tag_t t;
    logic st;
    if (!hold) begin
      st = m_stall();
      if (st) m_scnt++;
      if (ex_redirect) m_fcnt++;
      if (st || ex_redirect) begin
        t = '0;
        m_sel1 = 2'd0;
        m_sel2 = 2'd0;
      end else begin
        t.rd = id_rd_addr;
        t.rw = id_reg_write;
        t.mr = id_mem_read;
        m_sel1 = m_fwd(id_use_rs1, id_rs1_addr);
        m_sel2 = m_fwd(id_use_rs2, id_rs2_addr);
      end
      hist.push_front(t);
      void'(hist.pop_back());
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_stall"}, {31'd0, stall}, {31'd0, m_stall()});
    chk({tag, "_flush"}, {31'd0, flush}, {31'd0, ex_redirect});
    chk({tag, "_sel1"}, {30'd0, fwd_rs1_sel}, {30'd0, m_sel1});
    chk({tag, "_sel2"}, {30'd0, fwd_rs2_sel}, {30'd0, m_sel2});
`ifdef HAZARD_PERF_EN
    chk({tag, "_scnt"}, stall_cnt, m_scnt);
    chk({tag, "_fcnt"}, flush_cnt, m_fcnt);
`else
    chk({tag, "_scnt"}, stall_cnt, 32'd0);
    chk({tag, "_fcnt"}, flush_cnt, 32'd0);
`endif
  endtask

  // Present one ID instruction for a cycle; check mid-cycle, then advance the model at the edge.
  task automatic apply(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic u1, input logic u2, input logic rw, input logic mr,
                       input logic redir, input logic hld, input string tag);
    id_rs1_addr  = rs1;
    id_rs2_addr  = rs2;
    id_rd_addr   = rd;
    id_use_rs1   = u1;
    id_use_rs2   = u2;
    id_reg_write = rw;
    id_mem_read  = mr;
    ex_redirect  = redir;
    hold         = hld;
    @(negedge clk);
    chk_all(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    hold = 1'b0;
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_rd_addr = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0;
    ex_redirect = 1'b0;
    model_reset();
    #12;
    chk("rst_sel1", {30'd0, fwd_rs1_sel}, 32'd0);
    chk("rst_sel2", {30'd0, fwd_rs2_sel}, 32'd0);
    chk("rst_scnt", stall_cnt, 32'd0);
    rst_n = 1'b1;

    // Back-to-back: add x5 ; add x6,x5,x1
    apply(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "b2b_p");
    apply(5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "b2b_c");
    chk("b2b_rs1", {30'd0, fwd_rs1_sel}, 32'd1);
    chk("b2b_rs2", {30'd0, fwd_rs2_sel}, 32'd0);

    // Distance 2: add x5 ; nop ; sub x7,x5,x5
    apply(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "d2_p");
    apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "d2_nop");
    apply(5'd5, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "d2_c");
    chk("d2_rs1", {30'd0, fwd_rs1_sel}, 32'd2);
    chk("d2_rs2", {30'd0, fwd_rs2_sel}, 32'd2);

    // Writes to x0 never forward
    apply(5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "x0_p");
    apply(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "x0_c");
    chk("x0_rs1", {30'd0, fwd_rs1_sel}, 32'd0);
    chk("x0_rs2", {30'd0, fwd_rs2_sel}, 32'd0);

    // Load-use: lw x8 ; add x9,x8,x2 (stalls once, then forwards from WB)
    apply(5'd1, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "lu_ld");
    chk("lu_stall", {31'd0, stall}, 32'd0);
    id_rs1_addr = 5'd8; id_rs2_addr = 5'd2; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    id_rd_addr = 5'd9; id_mem_read = 1'b0;
    #1;
    chk("lu_stall_on", {31'd0, stall}, 32'd1);
    apply(5'd8, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "lu_st");
    chk("lu_bubble", {30'd0, fwd_rs1_sel}, 32'd0);
    apply(5'd8, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "lu_go");
    chk("lu_sel1", {30'd0, fwd_rs1_sel}, 32'd2);

    // Redirect during load-use: flush wins
    apply(5'd1, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "rd_ld");
    apply(5'd8, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "rd_fl");
    chk("rd_sel1", {30'd0, fwd_rs1_sel}, 32'd0);
    apply(5'd8, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "rd_nx");

    // Hold for 3 cycles mid-stall
    apply(5'd1, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "hd_ld");
    repeat (3) apply(5'd8, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "hd_hold");
    apply(5'd8, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "hd_st");
    apply(5'd8, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "hd_go");
    chk("hd_sel1", {30'd0, fwd_rs1_sel}, 32'd2);

    // Async reset between edges, just after a forwarding select was loaded
    apply(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "ar_p");
    apply(5'd5, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "ar_c");
    rst_n = 1'b0;
    #2;
    chk("ar_sel1", {30'd0, fwd_rs1_sel}, 32'd0);
    chk("ar_sel2", {30'd0, fwd_rs2_sel}, 32'd0);
    chk("ar_scnt", stall_cnt, 32'd0);
    chk("ar_fcnt", flush_cnt, 32'd0);
    model_reset();
    rst_n = 1'b1;

    // Five load-use stalls after reset
    for (int i = 0; i < 5; i++) begin
      apply(5'd1, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "s5_ld");
      apply(5'd8, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "s5_st");
    end
    apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "s5_nop");
`ifdef HAZARD_PERF_EN
    chk("s5_cnt", stall_cnt, 32'd5);
`else
    chk("s5_cnt", stall_cnt, 32'd0);
`endif

    // Random traffic over a small register window to provoke frequent matches
    for (int i = 0; i < 400; i++) begin
      apply(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 7) == 0), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
